// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the round-robin grant arbiter.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  localparam int HOLD_W = 4;

  // Legal range of the grant hold limit used by the timeout option
  localparam int MAX_HOLD_MIN = 1;
  localparam int MAX_HOLD_MAX = 15;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_priority_enc.sv
// Rotated 4:2 priority encoder: first set bit of req scanning from ptr upwards, wrapping 3->0.
module rr_priority_enc
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = '0;
    // Scan from the farthest position inwards so the closest hit to ptr is kept last
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + k[IDX_W-1:0];
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) begin
      onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for four level-held requesters with a registered one-hot grant.
// Optional grant timeout/preemption is enabled by defining RR_ARB_TIMEOUT_EN.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  if (MAX_HOLD < MAX_HOLD_MIN || MAX_HOLD > MAX_HOLD_MAX) begin : g_bad_hold
    $error("rr_grant_arbiter: MAX_HOLD out of range 1..15");
  end

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] nxt_ptr;
  logic [IDX_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick_req;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic             rel_ev;
  logic             preempt_cond;
  logic             rotate;

  assign rel_ev  = (state == BUSY) && !req[gnt_idx];
  assign rotate  = rel_ev || preempt_cond;
  assign nxt_ptr = gnt_idx + 2'd1;

  // On a rotation the outgoing owner is masked and the scan starts just past it
  assign pick_ptr = rotate ? nxt_ptr : ptr;
  assign pick_req = rotate ? (req & ~gnt) : req;

  rr_priority_enc u_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

`ifdef RR_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt;

  assign preempt_cond = (state == BUSY) && req[gnt_idx]
                        && (hold_cnt == HOLD_W'(MAX_HOLD)) && |(req & ~gnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      preempt <= preempt_cond;
      if (state == IDLE || rotate) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign preempt_cond = 1'b0;
  assign preempt      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= BUSY;
            gnt       <= pick_onehot;
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (rotate) begin
            ptr <= nxt_ptr;
            if (pick_any) begin
              gnt     <= pick_onehot;
              gnt_idx <= pick_idx;
            end else begin
              state     <= IDLE;
              gnt       <= '0;
              gnt_idx   <= '0;
              gnt_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Randomized scoreboard bench for rr_grant_arbiter against a queue-free owner/pointer model.
module tb_rr_grant_arbiter;

  localparam int HOLD = 8;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       pre;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  // Model state: current owner (-1 = none), rotation start and cycles held
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  rr_grant_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"}, gnt, 4'b0000);
    check({tag, "_idx"}, {2'b00, gnt_idx}, 4'b0000);
    check({tag, "_vld"}, {3'b000, gnt_valid}, 4'b0000);
    check({tag, "_pre"}, {3'b000, preempt}, 4'b0000);
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int d = 0; d < 4; d++) begin
      if (r[(p + d) % 4]) return (p + d) % 4;
    end
    return -1;
  endfunction

  // Apply one request vector for the coming edge, optionally after an async reset pulse
  task automatic drive(input logic [3:0] r, input bit with_rst);
    exp_t e;
    logic [3:0] own_mask;
    bit rot;
    bit pre;
    @(negedge clk);
    if (with_rst) begin
      rst = 1'b1;
      #1;
      check_idle_outputs("async_rst");
      #1;
      rst = 1'b0;
      m_owner = -1;
      m_ptr = 0;
      m_hold = 0;
    end
    req = r;
    pre = 1'b0;
    if (m_owner < 0) begin
      m_owner = pick(r, m_ptr);
      m_hold = 0;
    end else begin
      own_mask = 4'(1 << m_owner);
      rot = !r[m_owner];
`ifdef RR_ARB_TIMEOUT_EN
      if (!rot && m_hold == HOLD && (r & ~own_mask) != 4'b0000) begin
        rot = 1'b1;
        pre = 1'b1;
      end
`endif
      if (rot) begin
        m_ptr = (m_owner + 1) % 4;
        m_owner = pick(r & ~own_mask, m_ptr);
        m_hold = 0;
      end else if (m_hold < HOLD) begin
        m_hold++;
      end
    end
    e.gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    e.idx = (m_owner < 0) ? 2'b00 : 2'(m_owner);
    e.vld = (m_owner >= 0);
    e.pre = pre;
    sb.push_back(e);
  endtask

  // Monitor: every edge after stimulus has been issued produces one output to check
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("gnt", gnt, e.gnt);
        check("gnt_idx", {2'b00, gnt_idx}, {2'b00, e.idx});
        check("gnt_valid", {3'b000, gnt_valid}, {3'b000, e.vld});
        check("preempt", {3'b000, preempt}, {3'b000, e.pre});
      end
    end
  end

  initial begin
    logic [3:0] cur;
    logic [3:0] own_mask;
    rst = 1'b1;
    req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset_hold");

    // First edge out of reset grants requester 0
    drive(4'b1111, 1'b1);
    drive(4'b0000, 1'b0);

    // Single requester, then release to idle
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b0);
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);

    // Rotation fairness with all requesting; owner drops its bit for one cycle
    drive(4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 1'b0);
      own_mask = 4'(1 << m_owner);
      drive(4'b1111 & ~own_mask, 1'b0);
    end

    // Wrap and priority: release idx 1 so ptr=2, then 1011 picks idx 3, release wraps to 0
    drive(4'b0000, 1'b1);
    drive(4'b0010, 1'b0);
    drive(4'b0000, 1'b0);
    drive(4'b1011, 1'b0);
    drive(4'b1011, 1'b0);
    drive(4'b0011, 1'b0);
    drive(4'b0011, 1'b0);

    // Async reset while busy on idx 2, then 0110 picks idx 1
    drive(4'b0000, 1'b0);
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b0);
    drive(4'b0110, 1'b1);
    drive(4'b0110, 1'b0);

    // Long holds with a competitor pending (timeout path when enabled)
    drive(4'b0001, 1'b1);
    repeat (12) drive(4'b0011, 1'b0);
    repeat (12) drive(4'b0001, 1'b0);

    // Randomized traffic with occasional owner releases and resets
    cur = 4'b0000;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cur = 4'($urandom_range(0, 15));
      end else if (m_owner >= 0 && $urandom_range(0, 4) == 0) begin
        own_mask = 4'(1 << m_owner);
        cur = cur & ~own_mask;
      end
      drive(cur, $urandom_range(0, 99) == 0);
    end

    // Drain the scoreboard within a bounded number of edges
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d outputs still pending, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
